sha_block_sequencer: RTL and testbench
======================================

Name: sha_block_sequencer

Overview:
- Multi-block controller for the SHA-256 compression datapath.
- Accepts one 512-bit block per start handshake and sequences the datapath through its phases: IV load, working-variable load, 64 rounds, hash update.
- Drives round index, W-source select and message-word index; chains intermediate hash across blocks.
- Pulses o_valid only after the last block of a message.
- Sits between the host/padding front end and the message-schedule and round-function datapath.

Parameters:
ROUNDS, 64, number of compression rounds per block
MSG_WORDS, 16, number of message words taken directly from the block
RND_W, 6, width of round index (clog2(ROUNDS))

Ports:
usr_clk  input  1  system clock, rising edge
usr_reset_n  input  1  asynchronous reset, active low
i_start  input  1  request to process one block; accepted only in IDLE
i_first_blk  input  1  sampled with accepted i_start; block is first of message
i_last_blk  input  1  sampled with accepted i_start; block is last of message
i_stall  input  1  datapath hold; honoured in ROUND state only
o_ready  output  1  high in IDLE; start may be accepted
o_busy  output  1  high in every state except IDLE
o_init_iv  output  1  load H0..H7 from IV constants
o_load_wv  output  1  load working vars a..h from H
o_round_en  output  1  datapath executes round o_round this cycle
o_round  output  RND_W  current round index t
o_w_sel  output  1  0 = W from message word, 1 = W from schedule recurrence
o_msg_idx  output  4  message word index (t[3:0]), valid when o_w_sel=0
o_h_update  output  1  H_i += working vars
o_blk_done  output  1  one-cycle pulse at end of every block
o_valid  output  1  one-cycle pulse, digest final (last block only)

Behaviour:
- Reset: usr_reset_n low forces state IDLE, round counter 0, latched flags 0. All outputs 0 except o_ready=1.
- Reset asserted mid-operation aborts immediately. No o_blk_done or o_valid is issued for the aborted block.
- States: IDLE, INIT, LOAD, ROUND, UPDATE, DONE. Transitions:
  - IDLE -> INIT when i_start=1; latch i_first_blk and i_last_blk on that edge.
  - INIT -> LOAD unconditionally (1 cycle). o_init_iv=1 only if first flag latched; otherwise 0 and H is retained.
  - LOAD -> ROUND unconditionally (1 cycle). o_load_wv=1. Round counter cleared to 0.
  - ROUND: o_round_en=~i_stall.
    - Counter increments only when o_round_en=1.
    - Exit to UPDATE after the cycle with o_round=ROUNDS-1 and o_round_en=1.
    - No increment or wrap past ROUNDS-1.
  - UPDATE -> DONE (1 cycle). o_h_update=1.
  - DONE -> IDLE (1 cycle). o_blk_done=1; o_valid=1 only if last flag latched.
- Outputs are Moore-decoded from state and counter. o_round_en is the only output that also depends on an input (i_stall).
- o_round holds the counter value in ROUND and is 0 outside ROUND.
- o_w_sel=1 iff state ROUND and o_round>=MSG_WORDS.
- Latency, unstalled: start accepted at edge 0 gives INIT cycle 1, LOAD 2, rounds t=0..63 on cycles 3..66, UPDATE 67, DONE 68, o_ready again at cycle 69. Each stalled ROUND cycle adds exactly 1.
- i_start while busy: ignored, no queuing. i_start in the DONE cycle is also ignored.
- i_stall outside ROUND: ignored; INIT, LOAD, UPDATE and DONE are never extended.
- i_first_blk=1 and i_last_blk=1 together (single-block message): IV is loaded and o_valid fires.
- i_first_blk=0 on the very first block after reset: no IV load. This is the host's responsibility; the sequencer does no checking.
- Illegal state encodings return to IDLE on the next edge.

Decomposition:
- Shared package sha_pkg holds:
  - state encoding localparams: IDLE, INIT, LOAD, ROUND, UPDATE, DONE;
  - SHA256_ROUNDS=64, SHA256_MSG_WORDS=16;
  - round-index width.
- One sub-module, sha_round_counter: RND_W-bit counter with synchronous clear, enable, and terminal flag (count==ROUNDS-1 && en). The FSM uses the terminal flag for the ROUND->UPDATE transition.

Test Plan:
- Single block, first=1 last=1, start pulse at cycle 0, no stall -> o_init_iv at cycle 1, o_load_wv at 2, o_round 0..63 on cycles 3..66, o_w_sel rises at t=16 (cycle 19), o_h_update at 67, o_blk_done and o_valid at 68, o_ready at 69.
- Two-block message (first=1/last=0, then first=0/last=1) -> block 1: o_init_iv=1, o_blk_done=1, o_valid=0. Block 2: o_init_iv=0, o_valid=1 at its DONE.
- i_stall=1 for 5 cycles at t=10 and 3 cycles at t=63 -> o_round holds at 10 then at 63; o_round_en=0 while stalled; o_valid delayed to cycle 76.
- i_start pulsed during ROUND and again in DONE -> ignored; exactly one block processed, o_blk_done pulse count 1.
- usr_reset_n low at t=30 for 2 cycles -> all outputs 0 and o_ready=1 during reset. No o_valid afterwards. A new start after release runs the full 68-cycle sequence.
- i_stall=1 held through INIT, LOAD and UPDATE -> those phases still last exactly 1 cycle each.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared constants and state encoding for the SHA-256 block sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha_pkg;

    localparam int SHA256_ROUNDS    = 64;
    localparam int SHA256_MSG_WORDS = 16;
    localparam int SHA256_RND_W     = 6;

    // Sequencer phases; encodings 6 and 7 are unused and fall back to IDLE.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        LOAD   = 3'd2,
        ROUND  = 3'd3,
        UPDATE = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/sha_round_counter.sv
// Round index counter: sync clear, enable, terminal flag on the last enabled round.
// Latency: count updates one edge after en; term is combinational from count and en.
// Backpressure: en low (datapath stall) holds the count; saturates at ROUNDS-1.
module sha_round_counter
    import sha_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS,
    parameter int RND_W  = SHA256_RND_W
) (
    input  logic             usr_clk,
    input  logic             usr_reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [RND_W-1:0] count,
    output logic             term
);

    localparam logic [RND_W-1:0] LAST = RND_W'(ROUNDS - 1);

    assign term = en && (count == LAST);

    // Count enabled rounds; never step past the final round index.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sha_block_sequencer.sv
// Sequences the SHA-256 datapath per block: IV load, WV load, 64 rounds, H update.
// Latency: 68 cycles from accepted start to DONE when unstalled; +1 per stalled round.
// Backpressure: o_ready only in IDLE; i_stall freezes the ROUND phase only.
module sha_block_sequencer
    import sha_pkg::*;
#(
    parameter int ROUNDS    = SHA256_ROUNDS,
    parameter int MSG_WORDS = SHA256_MSG_WORDS,
    parameter int RND_W     = SHA256_RND_W
) (
    input  logic             usr_clk,
    input  logic             usr_reset_n,
    input  logic             i_start,
    input  logic             i_first_blk,
    input  logic             i_last_blk,
    input  logic             i_stall,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_init_iv,
    output logic             o_load_wv,
    output logic             o_round_en,
    output logic [RND_W-1:0] o_round,
    output logic             o_w_sel,
    output logic [3:0]       o_msg_idx,
    output logic             o_h_update,
    output logic             o_blk_done,
    output logic             o_valid
);

    localparam logic [RND_W-1:0] MSG_LIM = RND_W'(MSG_WORDS);

    state_t           state_q;
    state_t           state_d;
    logic             first_q;
    logic             last_q;
    logic             cnt_clr;
    logic             round_term;
    logic [RND_W-1:0] cnt;

    sha_round_counter #(
        .ROUNDS (ROUNDS),
        .RND_W  (RND_W)
    ) u_round_counter (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .clr         (cnt_clr),
        .en          (o_round_en),
        .count       (cnt),
        .term        (round_term)
    );

    // State register; reset aborts any block in flight.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture message-position flags only with an accepted start.
    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if ((state_q == IDLE) && i_start) begin
            first_q <= i_first_blk;
            last_q  <= i_last_blk;
        end
    end

    // Next-state and Moore output decode; only o_round_en also sees i_stall.
    always_comb begin
        state_d    = IDLE;
        o_ready    = 1'b0;
        o_busy     = 1'b1;
        o_init_iv  = 1'b0;
        o_load_wv  = 1'b0;
        o_round_en = 1'b0;
        o_round    = '0;
        o_w_sel    = 1'b0;
        o_msg_idx  = 4'd0;
        o_h_update = 1'b0;
        o_blk_done = 1'b0;
        o_valid    = 1'b0;
        cnt_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                state_d = i_start ? INIT : IDLE;
            end
            INIT: begin
                // Continuation blocks keep the chained H from the previous block.
                o_init_iv = first_q;
                state_d   = LOAD;
            end
            LOAD: begin
                o_load_wv = 1'b1;
                cnt_clr   = 1'b1;
                state_d   = ROUND;
            end
            ROUND: begin
                o_round_en = ~i_stall;
                o_round    = cnt;
                o_msg_idx  = cnt[3:0];
                o_w_sel    = (cnt >= MSG_LIM);
                state_d    = round_term ? UPDATE : ROUND;
            end
            UPDATE: begin
                o_h_update = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                o_blk_done = 1'b1;
                o_valid    = last_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Directed bench for sha_block_sequencer: per-cycle output vector against expected phase.
// Latency: n/a.
// Backpressure: exercises i_stall inside and outside ROUND, and ignored starts.
module tb_sha_block_sequencer;

    localparam int PH_IDLE   = 0;
    localparam int PH_INIT   = 1;
    localparam int PH_LOAD   = 2;
    localparam int PH_ROUND  = 3;
    localparam int PH_UPDATE = 4;
    localparam int PH_DONE   = 5;

    logic       usr_clk;
    logic       usr_reset_n;
    logic       i_start;
    logic       i_first_blk;
    logic       i_last_blk;
    logic       i_stall;
    logic       o_ready;
    logic       o_busy;
    logic       o_init_iv;
    logic       o_load_wv;
    logic       o_round_en;
    logic [5:0] o_round;
    logic       o_w_sel;
    logic [3:0] o_msg_idx;
    logic       o_h_update;
    logic       o_blk_done;
    logic       o_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [18:0] dut_vec;
    assign dut_vec = {o_ready, o_busy, o_init_iv, o_load_wv, o_round_en, o_round,
                      o_w_sel, o_msg_idx, o_h_update, o_blk_done, o_valid};

    sha_block_sequencer dut (
        .usr_clk     (usr_clk),
        .usr_reset_n (usr_reset_n),
        .i_start     (i_start),
        .i_first_blk (i_first_blk),
        .i_last_blk  (i_last_blk),
        .i_stall     (i_stall),
        .o_ready     (o_ready),
        .o_busy      (o_busy),
        .o_init_iv   (o_init_iv),
        .o_load_wv   (o_load_wv),
        .o_round_en  (o_round_en),
        .o_round     (o_round),
        .o_w_sel     (o_w_sel),
        .o_msg_idx   (o_msg_idx),
        .o_h_update  (o_h_update),
        .o_blk_done  (o_blk_done),
        .o_valid     (o_valid)
    );

    initial usr_clk = 1'b0;
    always #5 usr_clk = ~usr_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected output vector for a phase, round index and stall input.
    function automatic logic [18:0] exp_vec(input int ph, input int t, input bit stall,
                                            input bit first, input bit last);
        logic [5:0] r;
        r = (ph == PH_ROUND) ? 6'(t) : 6'd0;
        exp_vec = {ph == PH_IDLE, ph != PH_IDLE, (ph == PH_INIT) && first, ph == PH_LOAD,
                   (ph == PH_ROUND) && !stall, r, (ph == PH_ROUND) && (t >= 16), r[3:0],
                   ph == PH_UPDATE, ph == PH_DONE, (ph == PH_DONE) && last};
    endfunction

    // mode: 0 plain, 1 stalls at t=10 (5) and t=63 (3), 2 stall outside ROUND,
    //       3 extra starts during ROUND and DONE, 4 reset at t=30.
    task automatic run_block(input bit first, input bit last, input int mode,
                             output int valid_cyc, output int done_cnt, output int wsel_cyc);
        int ph, t, c, s1, s2;
        bit stall, fin;
        valid_cyc = -1;
        done_cnt  = 0;
        wsel_cyc  = -1;
        i_start     = 1'b1;
        i_first_blk = first;
        i_last_blk  = last;
        i_stall     = (mode == 2);
        @(negedge usr_clk);
        check("accept", {13'd0, dut_vec}, {13'd0, exp_vec(PH_IDLE, 0, 1'b0, first, last)});
        @(posedge usr_clk); #1;
        i_start     = 1'b0;
        i_first_blk = 1'b0;
        i_last_blk  = 1'b0;
        ph = PH_INIT; t = 0; s1 = 0; s2 = 0; fin = 1'b0; c = 1;
        while (!fin && c < 200) begin
            stall = 1'b0;
            if (mode == 1 && ph == PH_ROUND) begin
                if (t == 10 && s1 < 5) begin
                    stall = 1'b1; s1++;
                end else if (t == 63 && s2 < 3) begin
                    stall = 1'b1; s2++;
                end
            end
            if (mode == 2) stall = (ph != PH_ROUND);
            i_stall = stall;
            i_start = (mode == 3) && (c == 40 || c == 68);
            if (mode == 4 && ph == PH_ROUND && t == 30) begin
                usr_reset_n = 1'b0;
                i_stall     = 1'b0;
                repeat (2) begin
                    @(negedge usr_clk);
                    check("in_reset", {13'd0, dut_vec},
                          {13'd0, exp_vec(PH_IDLE, 0, 1'b0, 1'b0, 1'b0)});
                    if (o_valid) valid_cyc = c;
                    if (o_blk_done) done_cnt++;
                    @(posedge usr_clk); #1;
                end
                usr_reset_n = 1'b1;
                fin = 1'b1;
            end else begin
                @(negedge usr_clk);
                check($sformatf("cyc%0d", c), {13'd0, dut_vec},
                      {13'd0, exp_vec(ph, t, stall, first, last)});
                if (o_valid && valid_cyc < 0) valid_cyc = c;
                if (o_blk_done) done_cnt++;
                if (o_w_sel && wsel_cyc < 0) wsel_cyc = c;
                case (ph)
                    PH_INIT:   ph = PH_LOAD;
                    PH_LOAD:   begin ph = PH_ROUND; t = 0; end
                    PH_ROUND:  if (!stall) begin
                                   if (t == 63) ph = PH_UPDATE;
                                   else t++;
                               end
                    PH_UPDATE: ph = PH_DONE;
                    PH_DONE:   ph = PH_IDLE;
                    default:   fin = 1'b1;
                endcase
                @(posedge usr_clk); #1;
                c++;
            end
        end
        if (!fin) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int vc, dc, wc;
        usr_reset_n = 1'b0;
        i_start     = 1'b0;
        i_first_blk = 1'b0;
        i_last_blk  = 1'b0;
        i_stall     = 1'b0;
        @(negedge usr_clk);
        check("reset_state", {13'd0, dut_vec}, 32'h0004_0000);
        @(posedge usr_clk); #1;
        usr_reset_n = 1'b1;
        @(posedge usr_clk); #1;

        // Single-block message.
        run_block(1'b1, 1'b1, 0, vc, dc, wc);
        check("single_valid_cyc", 32'(vc), 32'd68);
        check("single_done_cnt", 32'(dc), 32'd1);
        check("single_wsel_cyc", 32'(wc), 32'd19);

        // Two-block message: no valid on the first, IV not reloaded on the second.
        run_block(1'b1, 1'b0, 0, vc, dc, wc);
        check("blk1_valid_none", 32'(vc), 32'hFFFF_FFFF);
        check("blk1_done_cnt", 32'(dc), 32'd1);
        run_block(1'b0, 1'b1, 0, vc, dc, wc);
        check("blk2_valid_cyc", 32'(vc), 32'd68);

        // Stalls inside ROUND stretch the block by 8 cycles.
        run_block(1'b1, 1'b1, 1, vc, dc, wc);
        check("stall_valid_cyc", 32'(vc), 32'd76);
        check("stall_done_cnt", 32'(dc), 32'd1);

        // Starts while busy and in DONE are dropped.
        run_block(1'b1, 1'b1, 3, vc, dc, wc);
        check("busy_start_done_cnt", 32'(dc), 32'd1);
        check("busy_start_valid_cyc", 32'(vc), 32'd68);

        // Reset mid-ROUND aborts with no completion pulses.
        run_block(1'b1, 1'b1, 4, vc, dc, wc);
        check("abort_no_valid", 32'(vc), 32'hFFFF_FFFF);
        check("abort_no_done", 32'(dc), 32'd0);
        repeat (4) begin
            @(negedge usr_clk);
            check("post_abort_idle", {13'd0, dut_vec}, 32'h0004_0000);
            @(posedge usr_clk); #1;
        end
        run_block(1'b1, 1'b1, 0, vc, dc, wc);
        check("post_abort_valid_cyc", 32'(vc), 32'd68);

        // Stall outside ROUND does not extend INIT/LOAD/UPDATE/DONE.
        run_block(1'b1, 1'b1, 2, vc, dc, wc);
        check("ext_stall_valid_cyc", 32'(vc), 32'd68);
        check("ext_stall_done_cnt", 32'(dc), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
